// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the EX-stage branch controller: funct3 codes,
// BHT counter states and small decode/update helpers.
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_t;

  // funct3 010/011 are not conditional branches
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

  // Taken decision from the comparator flags; bit 0 of funct3 inverts the sense
  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic raw;
    raw = f3[2] ? lt : eq;
    return f3_legal(f3) & (raw ^ f3[0]);
  endfunction

  // Saturating 2-bit counter step
  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    bht_state_t n;
    n = s;
    if (taken && (s != BHT_ST)) n = bht_state_t'(s + 2'd1);
    else if (!taken && (s != BHT_SNT)) n = bht_state_t'(s - 2'd1);
    return n;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Pipeline-facing signal bundle of the branch controller: fetch lookup,
// EX branch operands, comparator link and redirect outputs.
interface branch_ctrl_if;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic        stall;
  logic        br_un;
  logic        br_eq;
  logic        br_lt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        illegal_br;

  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
           ex_pred_taken, stall, br_eq, br_lt,
    input  if_pred_taken, br_un, redirect_valid, redirect_pc, illegal_br
  );

  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
           ex_pred_taken, stall, br_eq, br_lt,
    output if_pred_taken, br_un, redirect_valid, redirect_pc, illegal_br
  );
endinterface

// File: rtl/branch_ctrl_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one update port. Reads see the pre-update value.
module branch_ctrl_bht
  import branch_ctrl_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_state_t       rd_state_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int NUM = 1 << IDX_W;

  bht_state_t bht_q [NUM];
  bht_state_t upd_d;

  // Next value for the entry being trained
  always_comb begin
    upd_d = bht_next(bht_q[wr_idx_i], wr_taken_i);
  end

  // Counter array: all entries start weakly not-taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) bht_q[i] <= BHT_WNT;
    end else if (wr_en_i) begin
      bht_q[wr_idx_i] <= upd_d;
    end
  end

  assign rd_state_o = bht_q[rd_idx_i];

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch controller: funct3 decode, taken/mispredict resolution,
// one-cycle registered redirect, BHT training and performance counters.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  branch_ctrl_if.slave     bus,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  logic             legal;
  logic             taken;
  logic             fire;
  logic             mispred;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  bht_state_t       rd_state;

  // Upper/lower fetch PC bits and the BHT weak bit do not feed the prediction
  logic unused_bits;
  assign unused_bits = ^{bus.if_pc[31:BHT_IDX_W+2], bus.if_pc[1:0], rd_state[0]};

  assign bus.br_un         = bus.ex_funct3[1];
  assign bus.illegal_br    = bus.ex_valid & bus.ex_is_branch & ~legal;
  assign bus.if_pred_taken = rd_state[1];

  // Resolution, redirect next-state and counter next-state
  always_comb begin
    legal   = f3_legal(bus.ex_funct3);
    taken   = br_taken(bus.ex_funct3, bus.br_eq, bus.br_lt);
    // A branch sitting in EX while a redirect is out is wrong-path
    fire    = bus.ex_valid & bus.ex_is_branch & legal & ~bus.stall & ~redir_valid_q;
    mispred = fire & (taken != bus.ex_pred_taken);

    redir_valid_d = mispred;
    redir_pc_d    = redir_pc_q;
    if (mispred) redir_pc_d = taken ? bus.ex_target : (bus.ex_pc + 32'd4);

    if (cnt_clr_i) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else begin
      br_cnt_d  = br_cnt_q  + {{(CNT_W-1){1'b0}}, fire};
      mis_cnt_d = mis_cnt_q + {{(CNT_W-1){1'b0}}, mispred};
    end
  end

  // Redirect pulse and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign bus.redirect_valid = redir_valid_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign br_count_o         = br_cnt_q;
  assign mispred_count_o    = mis_cnt_q;

  branch_ctrl_bht #(
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (bus.if_pc[BHT_IDX_W+1:2]),
    .rd_state_o (rd_state),
    .wr_en_i    (fire),
    .wr_idx_i   (bus.ex_pc[BHT_IDX_W+1:2]),
    .wr_taken_i (taken)
  );

endmodule
